// File: rtl/qif_spike_decoder_if.sv
// Rate-result handshake between the spike decoder and its consumer.
// The decoder is the master: it offers rate_out/out_valid, the consumer returns out_ready.
interface qif_spike_decoder_if #(
    parameter int CNT_W = 8
);
    logic [CNT_W-1:0] rate_out;
    logic             out_valid;
    logic             out_ready;

    modport master (output rate_out, output out_valid, input out_ready);
    modport slave  (input rate_out, input out_valid, output out_ready);
endinterface

// File: rtl/qif_spike_decoder.sv
// Decodes the QIF neuron spike train into a per-window spike count (rate code)
// and the most recent inter-spike interval (temporal code).
module qif_spike_decoder #(
    parameter int WIN_W = 16,
    parameter int CNT_W = 8,
    parameter int ISI_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [WIN_W-1:0]       window_len,
    input  logic                   spike_in,
    qif_spike_decoder_if.master    rate_if,
    output logic                   overrun,
    output logic [ISI_W-1:0]       isi_out,
    output logic                   isi_valid
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic             spike_prev;
    logic [WIN_W-1:0] win_len_q;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] spike_cnt;
    logic [ISI_W-1:0] isi_timer;
    logic             isi_seen;
    logic [CNT_W-1:0] rate_q;
    logic             valid_q;

    logic             spike_edge;
    logic [WIN_W-1:0] win_len_in;
    logic [CNT_W-1:0] spike_sum;
    logic [ISI_W-1:0] isi_inc;
    logic             terminal;
    logic             xfer;

    assign rate_if.rate_out  = rate_q;
    assign rate_if.out_valid = valid_q;

    // A level held for several cycles is a single spike.
    assign spike_edge = spike_in & ~spike_prev;
    assign win_len_in = (window_len == '0) ? WIN_W'(1) : window_len;
    assign spike_sum  = (spike_cnt == '1) ? spike_cnt : spike_cnt + CNT_W'(spike_edge);
    assign isi_inc    = (isi_timer == '1) ? isi_timer : isi_timer + ISI_W'(1);
    assign terminal   = (win_cnt == win_len_q - WIN_W'(1));
    assign xfer       = valid_q & rate_if.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en)  state_nxt = RUN;
            RUN:     if (!en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spike_prev <= 1'b0;
            win_len_q  <= '0;
            win_cnt    <= '0;
            spike_cnt  <= '0;
            isi_timer  <= '0;
            isi_seen   <= 1'b0;
            rate_q     <= '0;
            valid_q    <= 1'b0;
            overrun    <= 1'b0;
            isi_out    <= '0;
            isi_valid  <= 1'b0;
        end else begin
            spike_prev <= spike_in;
            isi_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        win_len_q <= win_len_in;
                        win_cnt   <= '0;
                        spike_cnt <= '0;
                        isi_timer <= '0;
                        isi_seen  <= 1'b0;
                    end
                end
                RUN: begin
                    if (!en) begin
                        // rate_out and isi_out deliberately keep their last values.
                        valid_q   <= 1'b0;
                        overrun   <= 1'b0;
                        win_cnt   <= '0;
                        spike_cnt <= '0;
                        isi_timer <= '0;
                        isi_seen  <= 1'b0;
                    end else begin
                        if (terminal) begin
                            rate_q    <= spike_sum;
                            valid_q   <= 1'b1;
                            if (valid_q && !rate_if.out_ready) overrun <= 1'b1;
                            win_cnt   <= '0;
                            spike_cnt <= '0;
                            win_len_q <= win_len_in;
                        end else begin
                            win_cnt   <= win_cnt + WIN_W'(1);
                            spike_cnt <= spike_sum;
                            if (xfer) valid_q <= 1'b0;
                        end

                        // Interval timing runs across window boundaries.
                        if (spike_edge) begin
                            isi_timer <= ISI_W'(1);
                            isi_seen  <= 1'b1;
                            if (isi_seen) begin
                                isi_out   <= isi_timer;
                                isi_valid <= 1'b1;
                            end
                        end else begin
                            isi_timer <= isi_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_qif_spike_decoder.sv
// Scoreboard bench for qif_spike_decoder: each scenario's expected responses are
// derived from edge lists and window boundaries, queued, and checked by a monitor.
module tb_qif_spike_decoder;

    localparam int WIN_W = 16;
    localparam int CNT_W = 8;
    localparam int ISI_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             spike_in;
    logic [WIN_W-1:0] window_len;
    logic             overrun;
    logic [ISI_W-1:0] isi_out;
    logic             isi_valid;

    qif_spike_decoder_if #(.CNT_W(CNT_W)) rate_if ();

    qif_spike_decoder #(.WIN_W(WIN_W), .CNT_W(CNT_W), .ISI_W(ISI_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .window_len (window_len),
        .spike_in   (spike_in),
        .rate_if    (rate_if.master),
        .overrun    (overrun),
        .isi_out    (isi_out),
        .isi_valid  (isi_valid)
    );

    always #5 clk = ~clk;

    typedef struct { bit valid; bit ovr; int rate; int isi; } step_exp_t;
    typedef struct { int avail; int val; } evt_t;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int          step = 0;
    bit          mon_on = 1'b0;
    int          last_rate = 0;
    int          last_isi = 0;

    step_exp_t step_q[$];
    evt_t      rate_q[$];
    evt_t      isi_q[$];

    bit sp[];
    bit rdy[];
    int wl[];

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s step=%0d: got %0d expected %0d", name, step, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s step=%0d: event with nothing expected", name, step);
    endtask

    // Monitor: one step record per cycle, plus rate transfers and ISI pulses.
    step_exp_t se;
    evt_t      ev;
    bit        got;
    always @(negedge clk) begin
        if (mon_on) begin
            if (step_q.size() > 0) begin
                se = step_q.pop_front();
                check("out_valid", rate_if.out_valid, se.valid);
                check("overrun",   overrun,           se.ovr);
                check("rate_out",  rate_if.rate_out,  se.rate);
                check("isi_out",   isi_out,           se.isi);
            end else begin
                unexpected("step_record");
            end
            if (rate_if.out_valid && rate_if.out_ready) begin
                got = 1'b0;
                while (rate_q.size() > 0 && rate_q[0].avail <= step) begin
                    ev  = rate_q.pop_front();
                    got = 1'b1;
                end
                if (got) check("rate_xfer", rate_if.rate_out, ev.val);
                else     unexpected("rate_xfer");
            end
            if (isi_valid) begin
                if (isi_q.size() > 0) begin
                    ev = isi_q.pop_front();
                    check("isi_pulse_val",  isi_out, ev.val);
                    check("isi_pulse_time", step,    ev.avail);
                end else begin
                    unexpected("isi_pulse");
                end
            end
        end
    end

    task automatic setup(input int n, input int l);
        sp  = new[n + 3];
        rdy = new[n + 3];
        wl  = new[n + 3];
        foreach (sp[j]) begin
            sp[j]  = 1'b0;
            rdy[j] = 1'b1;
            wl[j]  = l;
        end
    endtask

    // Step 0 is the enabling IDLE cycle, steps 1..n run, step n+1 drops en, n+2 is idle.
    task automatic build_expect(input int n);
        int edges[$];
        int term_val[];
        int isi_at[];
        int s, l, t, cnt, d, p, rate, isi;
        bit pend, ovr;
        term_val = new[n + 3];
        isi_at   = new[n + 3];
        foreach (term_val[j]) begin
            term_val[j] = -1;
            isi_at[j]   = -1;
        end
        for (int i = 1; i <= n; i++)
            if (sp[i] && !sp[i-1]) edges.push_back(i);
        s = 1;
        l = (wl[0] == 0) ? 1 : wl[0];
        while (s + l - 1 <= n) begin
            t   = s + l - 1;
            cnt = 0;
            foreach (edges[k]) if (edges[k] >= s && edges[k] <= t) cnt++;
            term_val[t] = (cnt > 255) ? 255 : cnt;
            s = t + 1;
            l = (wl[t] == 0) ? 1 : wl[t];
        end
        for (int m = 1; m < edges.size(); m++) begin
            d = edges[m] - edges[m-1];
            if (d > 65535) d = 65535;
            isi_at[edges[m] + 1] = d;
            isi_q.push_back('{edges[m] + 1, d});
        end
        pend = 1'b0;
        ovr  = 1'b0;
        rate = last_rate;
        isi  = last_isi;
        for (int j = 0; j <= n + 2; j++) begin
            if (j >= 1) begin
                p = j - 1;
                if (p == n + 1) begin
                    pend = 1'b0;
                    ovr  = 1'b0;
                end else if (p >= 1) begin
                    if (term_val[p] >= 0) begin
                        if (pend && !rdy[p]) ovr = 1'b1;
                        pend = 1'b1;
                        rate = term_val[p];
                        rate_q.push_back('{j, term_val[p]});
                    end else if (pend && rdy[p]) begin
                        pend = 1'b0;
                    end
                end
            end
            if (isi_at[j] >= 0) isi = isi_at[j];
            step_q.push_back('{pend, ovr, rate, isi});
        end
        last_rate = rate;
        last_isi  = isi;
    endtask

    task automatic run(input int n);
        build_expect(n);
        for (int j = 0; j <= n + 2; j++) begin
            @(posedge clk);
            #1;
            step              = j;
            mon_on            = 1'b1;
            en                = (j <= n);
            spike_in          = sp[j];
            window_len        = WIN_W'(wl[j]);
            rate_if.out_ready = rdy[j];
        end
        @(posedge clk);
        #1;
        mon_on            = 1'b0;
        en                = 1'b0;
        spike_in          = 1'b0;
        rate_if.out_ready = 1'b0;
        check("rate_q_left", rate_q.size(), 0);
        check("isi_q_left",  isi_q.size(),  0);
        check("step_q_left", step_q.size(), 0);
        rate_q.delete();
        isi_q.delete();
        step_q.delete();
    endtask

    task automatic rand_scn(input int n);
        int cur;
        setup(n, 0);
        cur = $urandom_range(0, 12);
        for (int j = 0; j <= n; j++) begin
            if ($urandom_range(0, 7) == 0) cur = $urandom_range(0, 12);
            wl[j]  = cur;
            rdy[j] = ($urandom_range(0, 3) != 0);
            if (j >= 1) sp[j] = ($urandom_range(0, 2) == 0);
        end
        rdy[n + 1] = 1'b1;
        run(n);
    endtask

    initial begin
        #(64'd5_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b1;
        en                = 1'b0;
        spike_in          = 1'b0;
        window_len        = '0;
        rate_if.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", rate_if.out_valid, 0);
        check("rst_rate_out",  rate_if.rate_out,  0);
        check("rst_overrun",   overrun,           0);
        check("rst_isi_out",   isi_out,           0);
        check("rst_isi_valid", isi_valid,         0);
        rst = 1'b0;

        // Basic: spikes at window cycles 0,3,6,9 of a 10-cycle window.
        setup(10, 10);
        sp[1] = 1; sp[4] = 1; sp[7] = 1; sp[10] = 1;
        run(10);

        // One long level inside a 20-cycle window.
        setup(20, 20);
        for (int j = 5; j <= 9; j++) sp[j] = 1;
        run(20);

        // Spike count saturation: 260 edges in one window.
        setup(520, 520);
        for (int j = 1; j <= 520; j++) sp[j] = (j % 2 == 1);
        run(520);

        // Backpressure across two windows, then a single-cycle accept.
        setup(40, 8);
        for (int w = 0; w < 5; w++) begin
            sp[1 + 8*w + 1] = 1;
            sp[1 + 8*w + 4] = 1;
        end
        for (int j = 0; j <= 31; j++) rdy[j] = (j == 18);
        run(40);

        // Ready only on terminal cycles: overwrite-free reload.
        setup(24, 8);
        for (int w = 0; w < 3; w++) begin
            sp[1 + 8*w + 2] = 1;
            sp[1 + 8*w + 5] = 1;
        end
        for (int j = 0; j <= 24; j++) rdy[j] = (j == 8 || j == 16 || j == 24);
        run(24);

        // window_len = 0 behaves as a one-cycle window.
        setup(12, 0);
        for (int j = 1; j <= 12; j++) sp[j] = ($urandom_range(0, 1) == 1);
        run(12);

        // Window length changes mid-window; takes effect at the next window.
        setup(20, 4);
        for (int j = 0; j <= 5; j++) wl[j] = 10;
        for (int j = 1; j <= 20; j++) sp[j] = ($urandom_range(0, 2) == 0);
        run(20);

        // Interval timer saturation.
        setup(66010, 65535);
        sp[5] = 1;
        sp[66005] = 1;
        run(66010);

        for (int r = 0; r < 6; r++) rand_scn(40 + $urandom_range(0, 160));

        // Asynchronous reset in the middle of a window.
        @(posedge clk);
        #1;
        en = 1'b1;
        window_len = WIN_W'(3);
        rate_if.out_ready = 1'b0;
        spike_in = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            @(posedge clk);
            #1;
            spike_in = (j == 1 || j == 4);
        end
        @(negedge clk);
        check("pre_rst_valid", rate_if.out_valid, 1);
        check("pre_rst_rate",  rate_if.rate_out,  1);
        check("pre_rst_isi",   isi_out,           3);
        #2;
        rst = 1'b1;
        en  = 1'b0;
        spike_in = 1'b0;
        #1;
        check("arst_out_valid", rate_if.out_valid, 0);
        check("arst_rate_out",  rate_if.rate_out,  0);
        check("arst_overrun",   overrun,           0);
        check("arst_isi_out",   isi_out,           0);
        check("arst_isi_valid", isi_valid,         0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_rate = 0;
        last_isi  = 0;

        rand_scn(80);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/qif_spike_decoder.md
Name: qif_spike_decoder

Overview:
- Receiving end of the QIF neuron spike output (tt_um_QIFNeuron uo_out spike bit).
- Converts the spike train back into numbers: spike count per programmable window (rate code) and the last inter-spike interval (temporal code).
- The rate result is offered on a valid/ready handshake. The ISI result is a one-cycle strobe.
- Sits beside the neuron in the top wrapper. Drives uio_out/uo_out readback and feeds the cocotb bench.

Parameters:
- WIN_W, 16, width of window_len and of the internal window counter.
- CNT_W, 8, width of the spike count (rate_out).
- ISI_W, 16, width of the ISI timer and isi_out.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  decoder enable. Low forces IDLE.
- window_len  in  WIN_W  window length in cycles. Sampled at window start. 0 is treated as 1.
- spike_in  in  1  neuron spike level, same clock domain, may stay high for several cycles.
- rate_out  out  CNT_W  spike count of the last completed window.
- out_valid  out  1  rate_out holds unconsumed data.
- out_ready  in  1  consumer accepts rate_out.
- overrun  out  1  sticky: a window result overwrote an unconsumed one.
- isi_out  out  ISI_W  last inter-spike interval in cycles.
- isi_valid  out  1  one-cycle pulse when isi_out updates.

Behaviour:
- Reset (rst=1, asynchronous): all outputs 0, all internal registers 0, state IDLE. Applies immediately, including mid-window.
- Edge detect: spike_prev <= spike_in every cycle, in all states.
  - edge = spike_in & ~spike_prev.
  - A level held N cycles counts as one spike.
- FSM states: IDLE, RUN.
  - IDLE -> RUN when en=1. Entry loads win_len_q = max(window_len, 1), clears win_cnt, spike_cnt, isi_timer and isi_seen.
  - RUN -> IDLE when en=0. Effects: clear out_valid, overrun, isi_valid and the counters. rate_out and isi_out keep their values.
- Window (RUN):
  - win_cnt counts 0..win_len_q-1.
  - On every edge, spike_cnt increments, saturating at 2^CNT_W-1.
  - Terminal cycle (win_cnt = win_len_q-1):
    - rate_out <= spike_cnt + edge of this cycle (saturating).
    - out_valid <= 1.
    - win_cnt <= 0, spike_cnt <= 0.
    - win_len_q <= max(window_len, 1).
  - Latency: rate_out and out_valid change on the clock edge that ends the terminal cycle.
- Handshake:
  - Transfer occurs when out_valid & out_ready at a clock edge. out_valid then goes to 0 unless a new result loads on the same edge.
  - Terminal cycle with out_valid=1 and no transfer: overwrite rate_out, keep out_valid=1, set overrun=1.
  - Terminal cycle coincident with a transfer: load the new result, out_valid stays 1, no overrun.
  - overrun clears only on rst or on leaving RUN.
  - out_ready while out_valid=0 has no effect.
- ISI (RUN):
  - isi_timer saturates at 2^ISI_W-1.
  - On an edge: isi_timer <= 1. If isi_seen=1, then isi_out <= isi_timer and isi_valid <= 1 for one cycle. isi_seen <= 1.
  - Without an edge: isi_timer <= sat(isi_timer+1).
  - Edges at cycles t and t+d therefore give isi_out = d. The first edge after enable produces no isi_valid.
  - The ISI logic is independent of window boundaries.
- Width rules: all counters unsigned and saturating. No wrap-around anywhere.

Test Plan:
- Basic rate/ISI: en=1, window_len=10, one-cycle spikes at window cycles 0,3,6,9, out_ready=1 -> rate_out=4 and out_valid=1 for 1 cycle after cycle 9. isi_valid pulses 3 times with isi_out=3. No pulse on the first spike.
- Level spike: spike_in high for 5 cycles inside a window_len=20 window, no other spikes -> rate_out=1, no isi_valid.
- Saturation: CNT_W=8, window_len=1000, spike_in toggling every cycle (500 edges) -> rate_out=255. Spikes 70000 cycles apart -> isi_out=65535.
- Overrun/backpressure: window_len=8, 2 spikes per window, out_ready=0 for 2 windows -> after the 2nd window overrun=1, out_valid=1, rate_out=2 (second window value). Raise out_ready for 1 cycle -> out_valid=0 and overrun stays 1. Window end coincident with out_ready=1 -> out_valid stays 1 and no new overrun.
- Window edge cases: window_len=0 -> a result every cycle, rate_out=edge of that cycle. Change window_len from 10 to 4 mid-window -> current window completes at 10 cycles, next at 4.
- Reset/enable abort: assert rst mid-window asynchronously -> all outputs 0 before the next clk edge. Separately, drop en mid-window -> out_valid=0, overrun=0, rate_out and isi_out held. Re-enable -> fresh window from cycle 0, first spike gives no isi_valid.
